// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - arbitrates instruction-fetch and data requests onto one RAM port
// Data wins IDLE arbitration unless a waiting fetch has already been passed over STARVE_LIMIT times.
module mem_arbiter #(
  parameter int STARVE_LIMIT = 4,
  parameter int ADDR_W       = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic [ADDR_W-1:0] iload,
  output logic              iwait,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [ADDR_W-1:0] dstore,
  output logic [ADDR_W-1:0] dload,
  output logic              dwait,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [ADDR_W-1:0] ramstore,
  input  logic [ADDR_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ram_err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DACC = 2'd1,
    IACC = 2'd2
  } state_t;

  localparam logic [1:0] RS_ACCESS = 2'd2;
  localparam logic [1:0] RS_ERROR  = 2'd3;
  localparam logic [3:0] LP_LIMIT  = 4'(STARVE_LIMIT);

  state_t     r_state;
  state_t     w_next;
  logic [3:0] r_starve_cnt;
  logic       w_dreq;
  logic       w_starved;

  assign w_dreq    = dREN | dWEN;
  assign w_starved = w_dreq & iREN & (r_starve_cnt == LP_LIMIT);

  assign iload = ramload;
  assign dload = ramload;

  // The counter only moves on IDLE exits, so retries and wait states never count as extra grants.
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_state      <= IDLE;
      r_starve_cnt <= 4'd0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE) begin
        if (w_next == IACC) begin
          r_starve_cnt <= 4'd0;
        end else if ((w_next == DACC) && iREN && (r_starve_cnt < LP_LIMIT)) begin
          r_starve_cnt <= r_starve_cnt + 4'd1;
        end
      end
    end
  end

  always_comb begin
    w_next   = r_state;
    iwait    = 1'b1;
    dwait    = 1'b1;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ram_err  = 1'b0;

    case (r_state)
      IDLE: begin
        if (w_starved) begin
          w_next = IACC;
        end else if (w_dreq) begin
          w_next = DACC;
        end else if (iREN) begin
          w_next = IACC;
        end
      end

      DACC: begin
        // A dropped request is an abort: enables stay low and no completion is reported.
        if (!w_dreq) begin
          w_next = IDLE;
        end else begin
          ramaddr  = daddr;
          ramstore = dstore;
          ramWEN   = dWEN;
          ramREN   = dREN & ~dWEN;
          ram_err  = (ramstate == RS_ERROR);
          if (ramstate == RS_ACCESS) begin
            dwait  = 1'b0;
            w_next = IDLE;
          end
        end
      end

      IACC: begin
        if (!iREN) begin
          w_next = IDLE;
        end else begin
          ramaddr = iaddr;
          ramREN  = 1'b1;
          ram_err = (ramstate == RS_ERROR);
          if (ramstate == RS_ACCESS) begin
            iwait  = 1'b0;
            w_next = IDLE;
          end
        end
      end

      default: begin
        w_next = IDLE;
      end
    endcase

    // Reset masks the bus immediately, even if a grant was active before the edge.
    if (RST) begin
      iwait    = 1'b1;
      dwait    = 1'b1;
      ramREN   = 1'b0;
      ramWEN   = 1'b0;
      ramaddr  = '0;
      ramstore = '0;
      ram_err  = 1'b0;
    end
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4, max consecutive data grants while an instruction request waits; legal range 1..15.
REQ-002 Parameter ADDR_W, default 32, address and data width.
REQ-003 CLK  in  1  clock; all state on rising edge.
REQ-004 RST  in  1  reset, synchronous, active-high.
REQ-005 iREN  in  1  instruction fetch request.
REQ-006 iaddr  in  ADDR_W  fetch address.
REQ-007 iload  out  ADDR_W  fetch data, valid when iwait=0.
REQ-008 iwait  out  1  fetch not complete.
REQ-009 dREN / dWEN  in  1 each  data read / write request.
REQ-010 daddr, dstore  in  ADDR_W each  data address, write data.
REQ-011 dload  out  ADDR_W  read data, valid when dwait=0.
REQ-012 dwait  out  1  data access not complete.
REQ-013 ramREN, ramWEN  out  1 each  RAM read / write enable.
REQ-014 ramaddr, ramstore  out  ADDR_W each  RAM address, write data.
REQ-015 ramload  in  ADDR_W  RAM read data.
REQ-016 ramstate  in  2  FREE=0, BUSY=1, ACCESS=2, ERROR=3.
REQ-017 ram_err  out  1  one-cycle pulse per ERROR response seen while granted.

Function
REQ-018 FSM states IDLE, DACC, IACC, held in a register.
REQ-019 IDLE: ram enables 0; iwait=1, dwait=1; arbitration picks the next state at the clock edge.
REQ-020 Arbitration in IDLE: data request (dREN|dWEN) -> DACC; else iREN -> IACC; else stay IDLE.
REQ-021 Exception: both pending and starve_cnt==STARVE_LIMIT -> IACC.
REQ-022 starve_cnt (4 bits) increments on each IDLE->DACC transition with iREN=1, saturates at STARVE_LIMIT, and clears on any IDLE->IACC transition.
REQ-023 DACC outputs: ramaddr=daddr, ramstore=dstore.
REQ-024 DACC enables: ramWEN=dWEN; ramREN=dREN&~dWEN, so write wins when both are set.
REQ-025 DACC: iwait=1.
REQ-026 IACC outputs: ramaddr=iaddr, ramREN=1, ramWEN=0; dwait=1.
REQ-027 Completion: granted state and ramstate==ACCESS -> granted wait=0 that same cycle (combinational); dload/iload=ramload; next state IDLE.
REQ-028 Every transfer passes through IDLE afterwards (one turnaround cycle), so a request still high in its completion cycle is never re-served.
REQ-029 Minimum latency: request cycle + 1 cycle, with ACCESS returned on the first granted cycle.
REQ-030 ramstate BUSY/FREE while granted: hold state and outputs, wait=1.
REQ-031 ramstate ERROR while granted: ram_err=1 for that cycle, hold state, retry; wait stays 1.
REQ-032 Abort: the granted requester drops its request before ACCESS -> enables 0 that cycle, next state IDLE, no completion signalled.
REQ-033 dREN/dWEN changing to the other op mid-DACC is followed combinationally; no restart.
REQ-034 iload and dload are driven from ramload continuously.
REQ-035 Both iwait and dwait are never 0 in the same cycle.
REQ-036 ramREN and ramWEN are never 1 in the same cycle.
REQ-037 ramaddr=0 and ramstore=0 when no grant is active.

Reset
REQ-038 RST=1 at an edge: state=IDLE, starve_cnt=0, regardless of state.
REQ-039 Outputs while RST is asserted and the cycle after: ramREN=ramWEN=0, iwait=dwait=1, ram_err=0.
REQ-040 Reset mid-transfer discards that transfer with no completion; the requester must re-request.
REQ-041 After RST deasserts, first arbitration occurs at the next edge.

Verification
REQ-042 Fetch alone: iREN=1, iaddr=0x40, ACCESS on the first IACC cycle with ramload=0xDEADBEEF.
        -> iwait=0 and iload=0xDEADBEEF in cycle 2; IDLE in cycle 3.
REQ-043 Contention: iREN=dREN=1 in the same cycle, daddr=0x100, then iaddr=0x40.
        -> DACC first with ramaddr=0x100 and ramREN=1.
        -> IDLE, then IACC with ramaddr=0x40.
REQ-044 Starvation: dWEN held high with STARVE_LIMIT=4 and iREN=1, RAM always ACCESS.
        -> exactly 4 data writes complete, then one fetch, then data resumes; starve_cnt returns to 0.
REQ-045 Wait states and error: DACC read with ramstate BUSY,BUSY,ERROR,ACCESS.
        -> dwait=1 for 3 cycles, ram_err pulses once in cycle 3, dwait=0 in cycle 4.
REQ-046 Abort and reset: dREN dropped while BUSY.
        -> ramREN=0 the same cycle, then IDLE.
        RST during an IACC BUSY cycle.
        -> IDLE next cycle, iwait=1, no ram enables.
REQ-047 Every cycle of every test checks: ~(ramREN&ramWEN) and (iwait|dwait).
